// File: rtl/epochtv1_vidcap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : epochtv1_vidcap_pkg
// Description : Shared constants, arm-FSM state type and the 24-bit-per-step
//               reflected CRC-32 update used by the video capture monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package epochtv1_vidcap_pkg;

  // CRC-32 IEEE, normal (MSB-first) polynomial form and initial value.
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Arm FSM: IDLE until the first VS edge, then every VS edge closes a frame.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arm_state_t;

  // Bit reversal, used to turn the normal polynomial into the reflected one.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // One reflected CRC step over a 24-bit pixel. Bytes are absorbed in the
  // order R, G, B, each LSB first, matching a byte-wise reflected CRC-32.
  function automatic logic [31:0] crc32_refl_d24(input logic [31:0] crc,
                                                 input logic [23:0] data);
    logic [31:0] c;
    logic [31:0] poly_r;
    logic [23:0] d;
    c      = crc;
    poly_r = bitrev32(CRC_POLY);
    d      = {data[7:0], data[15:8], data[23:16]};
    for (int i = 0; i < 24; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ poly_r;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/epochtv1_vidcap_crc.sv
`default_nettype none
// ============================================================================
// Module      : epochtv1_vidcap_crc
// Description : Combinational CRC-32 step absorbing one 24-bit RGB pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module epochtv1_vidcap_crc
  import epochtv1_vidcap_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [23:0] data,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_refl_d24(crc_in, data);

endmodule
`default_nettype wire

// File: rtl/epochtv1_vidcap.sv
`default_nettype none
// ============================================================================
// Module      : epochtv1_vidcap
// Description : Video-stream capture monitor. Measures line/frame geometry and
//               a CRC-32 of the active pixels per frame, latching the results
//               and pulsing DONE at every frame boundary (VS edge).
// Revision    : 1.0 - initial release
// ============================================================================
module epochtv1_vidcap
  import epochtv1_vidcap_pkg::*;
#(
  parameter logic SYNC_ACT = 1'b1,
  parameter int   HW       = 11,
  parameter int   VW       = 10
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          CE,
  input  logic          DE,
  input  logic          HS,
  input  logic          VS,
  input  logic [23:0]   RGB,
  output logic [HW-1:0] HTOT,
  output logic [HW-1:0] HACT,
  output logic [VW-1:0] VTOT,
  output logic [VW-1:0] VACT,
  output logic [31:0]   CRC,
  output logic [15:0]   FCNT,
  output logic          OVF,
  output logic          VALID,
  output logic          DONE
);

  localparam logic [HW-1:0] c_h_max = {HW{1'b1}};
  localparam logic [HW-1:0] c_h_one = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] c_v_max = {VW{1'b1}};
  localparam logic [VW-1:0] c_v_one = {{(VW-1){1'b0}}, 1'b1};

  arm_state_t    r_state;
  arm_state_t    w_state_nxt;

  logic          r_hs_prev;
  logic          r_vs_prev;
  logic          w_hs_edge;
  logic          w_vs_edge;
  logic          w_close;

  logic [HW-1:0] r_hcnt,      w_hcnt_nxt;
  logic [HW-1:0] r_hde,       w_hde_nxt;
  logic [HW-1:0] r_htot_last, w_htot_last_nxt;
  logic [HW-1:0] r_hact_last, w_hact_last_nxt;
  logic [VW-1:0] r_vcnt,      w_vcnt_nxt;
  logic [VW-1:0] r_vde,       w_vde_nxt;
  logic [31:0]   r_crc,       w_crc_nxt;
  logic          r_ovf_flag,  w_ovf_nxt;

  logic [31:0]   w_crc_base;
  logic [31:0]   w_crc_step;
  logic [31:0]   w_crc_upd;

  logic          w_line_open;
  logic [HW-1:0] w_hact_close;
  logic          w_vtot_sat;
  logic          w_vact_sat;
  logic [VW-1:0] w_vtot_close;
  logic [VW-1:0] w_vact_close;

  // Sync edges are evaluated tick-to-tick only; non-CE cycles are invisible.
  assign w_hs_edge = CE && (HS == SYNC_ACT) && (r_hs_prev != SYNC_ACT);
  assign w_vs_edge = CE && (VS == SYNC_ACT) && (r_vs_prev != SYNC_ACT);
  assign w_close   = w_vs_edge && (r_state == ST_RUN);

  // A VS edge restarts the CRC, and the pixel on that tick already belongs
  // to the new frame, so it is absorbed on top of the fresh init value.
  assign w_crc_base = w_vs_edge ? CRC_INIT : r_crc;
  assign w_crc_upd  = DE ? w_crc_step : w_crc_base;

  epochtv1_vidcap_crc u_crc (
    .crc_in  (w_crc_base),
    .data    (RGB),
    .crc_out (w_crc_step)
  );

  // Frame-close values: the line still open at the VS edge counts as a line.
  assign w_line_open  = (r_hde != '0);
  assign w_hact_close = w_line_open ? r_hde : r_hact_last;
  assign w_vtot_sat   = (r_vcnt == c_v_max);
  assign w_vact_sat   = w_line_open && (r_vde == c_v_max);
  assign w_vtot_close = w_vtot_sat ? c_v_max : (r_vcnt + c_v_one);
  assign w_vact_close = !w_line_open ? r_vde :
                        (w_vact_sat ? c_v_max : (r_vde + c_v_one));

  // Arm FSM state register.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arm FSM next state: the first VS edge arms, after that it stays armed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_vs_edge) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Previous-sync registers, sampled on ticks, reset to the inactive level.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_hs_prev <= ~SYNC_ACT;
      r_vs_prev <= ~SYNC_ACT;
    end else if (CE) begin
      r_hs_prev <= HS;
      r_vs_prev <= VS;
    end
  end

  // Running-counter next values: VS restart, HS line close, or plain tick.
  always_comb begin
    w_hcnt_nxt      = r_hcnt;
    w_hde_nxt       = r_hde;
    w_htot_last_nxt = r_htot_last;
    w_hact_last_nxt = r_hact_last;
    w_vcnt_nxt      = r_vcnt;
    w_vde_nxt       = r_vde;
    w_crc_nxt       = r_crc;
    w_ovf_nxt       = r_ovf_flag;
    if (CE) begin
      if (w_vs_edge) begin
        // New frame; a coincident HS edge is absorbed here, not counted.
        w_hcnt_nxt      = c_h_one;
        w_hde_nxt       = {{(HW-1){1'b0}}, DE};
        w_htot_last_nxt = '0;
        w_hact_last_nxt = '0;
        w_vcnt_nxt      = '0;
        w_vde_nxt       = '0;
        w_crc_nxt       = w_crc_upd;
        w_ovf_nxt       = 1'b0;
      end else if (r_state == ST_RUN) begin
        w_crc_nxt = w_crc_upd;
        if (w_hs_edge) begin
          w_htot_last_nxt = r_hcnt;
          if (r_hde != '0) begin
            w_hact_last_nxt = r_hde;
            if (r_vde == c_v_max) w_ovf_nxt = 1'b1;
            else                  w_vde_nxt = r_vde + c_v_one;
          end
          if (r_vcnt == c_v_max) w_ovf_nxt  = 1'b1;
          else                   w_vcnt_nxt = r_vcnt + c_v_one;
          w_hcnt_nxt = c_h_one;
          w_hde_nxt  = {{(HW-1){1'b0}}, DE};
        end else begin
          if (r_hcnt == c_h_max) w_ovf_nxt  = 1'b1;
          else                   w_hcnt_nxt = r_hcnt + c_h_one;
          if (DE) begin
            if (r_hde == c_h_max) w_ovf_nxt = 1'b1;
            else                  w_hde_nxt = r_hde + c_h_one;
          end
        end
      end
    end
  end

  // Running-counter registers.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_hcnt      <= '0;
      r_hde       <= '0;
      r_htot_last <= '0;
      r_hact_last <= '0;
      r_vcnt      <= '0;
      r_vde       <= '0;
      r_crc       <= CRC_INIT;
      r_ovf_flag  <= 1'b0;
    end else begin
      r_hcnt      <= w_hcnt_nxt;
      r_hde       <= w_hde_nxt;
      r_htot_last <= w_htot_last_nxt;
      r_hact_last <= w_hact_last_nxt;
      r_vcnt      <= w_vcnt_nxt;
      r_vde       <= w_vde_nxt;
      r_crc       <= w_crc_nxt;
      r_ovf_flag  <= w_ovf_nxt;
    end
  end

  // Result registers: latched and DONE pulsed on every frame close.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      HTOT  <= '0;
      HACT  <= '0;
      VTOT  <= '0;
      VACT  <= '0;
      CRC   <= '0;
      FCNT  <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (w_close) begin
        HTOT  <= r_htot_last;
        HACT  <= w_hact_close;
        VTOT  <= w_vtot_close;
        VACT  <= w_vact_close;
        CRC   <= ~r_crc;
        FCNT  <= FCNT + 16'd1;
        OVF   <= r_ovf_flag | w_vtot_sat | w_vact_sat;
        VALID <= 1'b1;
        DONE  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_epochtv1_vidcap.sv
`default_nettype none
// ============================================================================
// Module      : tb_epochtv1_vidcap
// Description : Self-checking bench for epochtv1_vidcap. Synthetic frames are
//               generated from a vector table; expected results are queued as
//               each frame is driven and compared when DONE fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_epochtv1_vidcap;

  localparam int HW = 11;
  localparam int VW = 10;

  logic          CLK = 1'b0;
  logic          RESB;
  logic          CE;
  logic          DE;
  logic          HS;
  logic          VS;
  logic [23:0]   RGB;
  logic [HW-1:0] HTOT;
  logic [HW-1:0] HACT;
  logic [VW-1:0] VTOT;
  logic [VW-1:0] VACT;
  logic [31:0]   CRC;
  logic [15:0]   FCNT;
  logic          OVF;
  logic          VALID;
  logic          DONE;

  epochtv1_vidcap #(
    .SYNC_ACT (1'b1),
    .HW       (HW),
    .VW       (VW)
  ) dut (
    .CLK   (CLK),
    .RESB  (RESB),
    .CE    (CE),
    .DE    (DE),
    .HS    (HS),
    .VS    (VS),
    .RGB   (RGB),
    .HTOT  (HTOT),
    .HACT  (HACT),
    .VTOT  (VTOT),
    .VACT  (VACT),
    .CRC   (CRC),
    .FCNT  (FCNT),
    .OVF   (OVF),
    .VALID (VALID),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  // Frame recipe plus the hand-derived geometry it must produce.
  typedef struct {
    int line_len;
    int n_lines;
    int de_s;
    int de_e;
    int de_l0;
    int de_l1;
    int ce_div;
    int mode;      // 0: counter pixels, 1: "123456789" pixels, 2: no DE
    int e_htot;
    int e_hact;
    int e_vtot;
    int e_vact;
    int e_ovf;
  } vec_t;

  typedef struct {
    logic [HW-1:0] htot;
    logic [HW-1:0] hact;
    logic [VW-1:0] vtot;
    logic [VW-1:0] vact;
    logic [31:0]   crc;
    logic [15:0]   fcnt;
    logic          ovf;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  exp_t mon_e;
  int   errors    = 0;
  int   checks    = 0;
  int   exp_fcnt  = 0;
  logic ce_q      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always @(posedge CLK) ce_q <= CE;

  // Monitor: DONE must stay low after non-CE cycles; otherwise each DONE pops
  // the oldest expected frame from the scoreboard.
  always @(negedge CLK) begin
    if (!ce_q) begin
      chk("done_without_ce", {63'd0, DONE}, 64'd0);
    end else if (DONE) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("htot",  {53'd0, HTOT}, {53'd0, mon_e.htot});
        chk("hact",  {53'd0, HACT}, {53'd0, mon_e.hact});
        chk("vtot",  {54'd0, VTOT}, {54'd0, mon_e.vtot});
        chk("vact",  {54'd0, VACT}, {54'd0, mon_e.vact});
        chk("crc",   {32'd0, CRC},  {32'd0, mon_e.crc});
        chk("fcnt",  {48'd0, FCNT}, {48'd0, mon_e.fcnt});
        chk("ovf",   {63'd0, OVF},  {63'd0, mon_e.ovf});
        chk("valid", {63'd0, VALID}, 64'd1);
      end
    end
  end

  // One pixel tick followed by (ce_div-1) idle cycles carrying junk inputs.
  task automatic tick(input int ce_div, input logic hs, input logic vs,
                      input logic de, input logic [23:0] rgb);
    HS = hs; VS = vs; DE = de; RGB = rgb; CE = 1'b1;
    @(negedge CLK);
    for (int c = 1; c < ce_div; c++) begin
      CE  = 1'b0;
      HS  = 1'($urandom);
      VS  = 1'($urandom);
      DE  = 1'($urandom);
      RGB = 24'($urandom);
      @(negedge CLK);
    end
  endtask

  // Drive one frame (VS+HS on its first tick) and queue its expected result.
  task automatic gen_frame(input vec_t v, input int idx);
    logic [31:0] crc;
    logic [23:0] pix;
    logic [23:0] special [3];
    logic        de;
    exp_t        e;
    special[0] = 24'h313233;
    special[1] = 24'h343536;
    special[2] = 24'h373839;
    crc = 32'hFFFFFFFF;
    for (int l = 0; l < v.n_lines; l++) begin
      for (int t = 0; t < v.line_len; t++) begin
        case (v.mode)
          0: begin
            de  = (l >= v.de_l0) && (l <= v.de_l1) && (t >= v.de_s) && (t <= v.de_e);
            pix = {l[7:0], t[7:0], 8'(l * 7 + t + idx)};
          end
          1: begin
            de  = (l == 1) && (t >= 3) && (t <= 5);
            pix = de ? special[t-3] : 24'($urandom);
          end
          default: begin
            de  = 1'b0;
            pix = 24'($urandom);
          end
        endcase
        if (de) crc = crc_byte(crc_byte(crc_byte(crc, pix[23:16]), pix[15:8]), pix[7:0]);
        tick(v.ce_div, (t == 0), (l == 0) && (t == 0), de, pix);
      end
    end
    exp_fcnt++;
    e.htot = HW'(v.e_htot);
    e.hact = HW'(v.e_hact);
    e.vtot = VW'(v.e_vtot);
    e.vact = VW'(v.e_vact);
    e.crc  = (v.mode == 1) ? 32'hCBF43926 : (v.mode == 2) ? 32'h00000000 : ~crc;
    e.fcnt = 16'(exp_fcnt);
    e.ovf  = (v.e_ovf != 0);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    CE = 1'b0; HS = 1'b0; VS = 1'b0; DE = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_htot"},  {53'd0, HTOT}, 64'd0);
    chk({tag, "_hact"},  {53'd0, HACT}, 64'd0);
    chk({tag, "_vtot"},  {54'd0, VTOT}, 64'd0);
    chk({tag, "_vact"},  {54'd0, VACT}, 64'd0);
    chk({tag, "_crc"},   {32'd0, CRC},  64'd0);
    chk({tag, "_fcnt"},  {48'd0, FCNT}, 64'd0);
    chk({tag, "_ovf"},   {63'd0, OVF},  64'd0);
    chk({tag, "_valid"}, {63'd0, VALID}, 64'd0);
    chk({tag, "_done"},  {63'd0, DONE}, 64'd0);
  endtask

  initial begin
    //          len   nl de_s de_e l0 l1 ce md  htot hact vtot vact ovf
    vecs[0] = '{10,   6,  3,   6, 1, 3, 1, 0,  10,   4,   6,   3,  0};
    vecs[1] = '{10,   6,  3,   6, 1, 3, 3, 0,  10,   4,   6,   3,  0};
    vecs[2] = '{10,   6,  0,   0, 0, 0, 1, 1,  10,   3,   6,   1,  0};
    vecs[3] = '{10,   6,  0,   0, 0, 0, 1, 2,  10,   0,   6,   0,  0};
    vecs[4] = '{2100, 2,  3,   6, 0, 0, 1, 0,  2047, 4,   2,   1,  1};
    vecs[5] = '{10,   6,  3,   6, 1, 3, 1, 0,  10,   4,   6,   3,  0};
    vecs[6] = '{16,   4,  0,  15, 0, 3, 1, 0,  16,   16,  4,   4,  0};

    RESB = 1'b0; CE = 1'b0; DE = 1'b0; HS = 1'b0; VS = 1'b0; RGB = '0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RESB = 1'b1;
    idle(2);

    // HS activity before any VS edge must not produce results.
    for (int i = 0; i < 30; i++) tick(1, (i % 10) == 0, 1'b0, (i % 10) == 4, 24'h0A0B0C);
    idle(2);
    chk("pre_arm_valid", {63'd0, VALID}, 64'd0);

    for (int i = 0; i < 7; i++) gen_frame(vecs[i], i);
    tick(1, 1'b1, 1'b1, 1'b0, 24'h0);   // closes the last table frame
    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("fcnt_total", {48'd0, FCNT}, 64'd7);

    // Mid-frame reset: partial lines, async reset, then re-arm.
    for (int i = 0; i < 25; i++) tick(1, (i % 10) == 0, 1'b0, (i % 10) == 5, 24'h123456);
    #2 RESB = 1'b0;
    #1 chk_all_zero("midreset");
    sb.delete();
    exp_fcnt = 0;
    @(negedge CLK);
    RESB = 1'b1;
    idle(2);
    gen_frame(vecs[0], 10);              // first VS edge re-arms
    gen_frame(vecs[6], 11);              // closes the previous frame, FCNT=1
    tick(1, 1'b1, 1'b1, 1'b0, 24'h0);
    idle(3);
    chk("sb_drained_after_reset", 64'(sb.size()), 64'd0);
    chk("fcnt_after_reset", {48'd0, FCNT}, 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
